// File: rtl/lbp_pkg.sv
// Shared geometry, state encoding and border helper for the LBP image host.
package lbp_pkg;

  localparam int IMG_W        = 128;
  localparam int IMG_H        = 128;
  localparam int AW           = 14;
  localparam int XW           = $clog2(IMG_W);
  localparam int YW           = AW - XW;
  localparam int LBP_EXPECTED = (IMG_W - 2) * (IMG_H - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } host_state_t;

  // Row-major address: low XW bits are the column, the rest the row.
  function automatic logic is_border(input logic [AW-1:0] addr);
    logic [XW-1:0] col;
    logic [YW-1:0] row;
    col = addr[XW-1:0];
    row = addr[AW-1:XW];
    return (row == '0) || (row == YW'(IMG_H - 1)) || (col == '0) || (col == '1);
  endfunction

endpackage

// File: rtl/lbp_img_ram.sv
// Byte-wide RAM: one synchronous write port, one asynchronous read port.
// Contents are never reset.
module lbp_img_ram #(
  parameter int AW    = 14,
  parameter int DEPTH = 1 << AW
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem [DEPTH];

  // Write port: commit on the rising edge when enabled.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/lbp_img_host.sv
// Memory-side responder for the LBP engine: serves the gray image, captures
// LBP results, and exposes registered readback plus completion status.
module lbp_img_host #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 14
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ld_we,
  input  logic [AW-1:0]            ld_addr,
  input  logic [7:0]               ld_data,
  input  logic                     ld_done,
  input  logic                     host_clr,
  input  logic [AW-1:0]            gray_addr,
  input  logic                     gray_req,
  output logic                     gray_ready,
  output logic [7:0]               gray_data,
  input  logic [AW-1:0]            lbp_addr,
  input  logic                     lbp_valid,
  input  logic [7:0]               lbp_data,
  input  logic                     finish,
  input  logic [AW-1:0]            rd_addr,
  output logic [7:0]               rd_data,
  output logic                     done,
  output logic [AW:0]              wr_cnt,
  output logic                     err_border,
  output lbp_pkg::host_state_t     dbg_state
);

  import lbp_pkg::*;

  // Handshake: gray_ready is a level that is high for the whole SERVE phase.
  // A read is gray_req && gray_ready and is answered combinationally in the
  // same cycle. lbp_valid has no backpressure: every lbp_valid cycle in SERVE
  // is a completed write; outside SERVE it is dropped silently.

  host_state_t state_q, state_d;
  logic [AW:0] wr_cnt_q, wr_cnt_d;
  logic        err_q, err_d;
  logic [7:0]  rd_q, rd_d;
  logic        img_we, res_we;
  logic [7:0]  img_rdata, res_rdata;

  lbp_img_ram #(.AW(AW), .DEPTH(IMG_W * IMG_H)) img_ram (
    .clk_i   (clk),
    .we_i    (img_we),
    .waddr_i (ld_addr),
    .wdata_i (ld_data),
    .raddr_i (gray_addr),
    .rdata_o (img_rdata)
  );

  lbp_img_ram #(.AW(AW), .DEPTH(IMG_W * IMG_H)) res_ram (
    .clk_i   (clk),
    .we_i    (res_we),
    .waddr_i (lbp_addr),
    .wdata_i (lbp_data),
    .raddr_i (rd_addr),
    .rdata_o (res_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state: load -> serve -> done -> idle, each on its own pulse/level.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ld_done)  state_d = SERVE;
      SERVE:   if (finish)   state_d = DONE;
      DONE:    if (host_clr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and write enables decoded from the current state.
  always_comb begin
    gray_ready = (state_q == SERVE);
    done       = (state_q == DONE);
    img_we     = ld_we && (state_q == IDLE);
    res_we     = lbp_valid && (state_q == SERVE);
    gray_data  = (gray_ready && gray_req) ? img_rdata : 8'h00;
  end

  // Result counter, sticky border flag and readback data next values.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    err_d    = err_q;
    if (res_we) begin
      if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 1'b1;
      if (is_border(lbp_addr)) err_d = 1'b1;
    end
    if ((state_q == DONE) && host_clr) begin
      wr_cnt_d = '0;
      err_d    = 1'b0;
    end
    rd_d = is_border(rd_addr) ? 8'h00 : res_rdata;
  end

  // Status and readback registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt_q <= '0;
      err_q    <= 1'b0;
      rd_q     <= 8'h00;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
    end
  end

  assign wr_cnt     = wr_cnt_q;
  assign err_border = err_q;
  assign rd_data    = rd_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_lbp_img_host.sv
// Self-checking bench for lbp_img_host: randomized traffic against a
// behavioural model, plus directed scenarios with literal expectations.
module tb_lbp_img_host;

  localparam int W       = 128;
  localparam int H       = 128;
  localparam int AW      = 14;
  localparam int N       = W * H;
  localparam int CNT_MAX = (1 << (AW + 1)) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          ld_we = 1'b0, ld_done = 1'b0, host_clr = 1'b0;
  logic [AW-1:0] ld_addr = '0, gray_addr = '0, lbp_addr = '0, rd_addr = '0;
  logic [7:0]    ld_data = '0, lbp_data = '0;
  logic          gray_req = 1'b0, lbp_valid = 1'b0, finish = 1'b0;
  logic          gray_ready, done, err_border;
  logic [7:0]    gray_data, rd_data;
  logic [AW:0]   wr_cnt;
  lbp_pkg::host_state_t dbg_state;

  always #5 clk = ~clk;

  lbp_img_host dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_done    (ld_done),
    .host_clr   (host_clr),
    .gray_addr  (gray_addr),
    .gray_req   (gray_req),
    .gray_ready (gray_ready),
    .gray_data  (gray_data),
    .lbp_addr   (lbp_addr),
    .lbp_valid  (lbp_valid),
    .lbp_data   (lbp_data),
    .finish     (finish),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .done       (done),
    .wr_cnt     (wr_cnt),
    .err_border (err_border),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int         m_st;           // 0 = idle, 1 = serving, 2 = done
  logic [7:0] m_img [N];
  bit         m_img_ok [N];
  logic [7:0] m_res [N];
  bit         m_res_ok [N];
  int         m_cnt;
  bit         m_err;
  int         m_rd;
  bit         m_rd_ok;

  function automatic bit border(input int a);
    int r, c;
    r = a / W;
    c = a % W;
    return (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
  endfunction

  // Classic 3x3 LBP: bit k set when neighbour k >= centre.
  function automatic logic [7:0] lbp_ref(input int p);
    int dr [8] = '{-1, -1, -1, 0, 1, 1, 1, 0};
    int dc [8] = '{-1, 0, 1, 1, 1, 0, -1, -1};
    int r, c;
    logic [7:0] v;
    r = p / W;
    c = p % W;
    v = 8'h00;
    for (int k = 0; k < 8; k++)
      if (m_img[(r + dr[k]) * W + c + dc[k]] >= m_img[p]) v[k] = 1'b1;
    return v;
  endfunction

  function automatic lbp_pkg::host_state_t exp_state(input int s);
    if (s == 1) return lbp_pkg::SERVE;
    if (s == 2) return lbp_pkg::DONE;
    return lbp_pkg::IDLE;
  endfunction

  // Compare process: 4 time units after the falling edge (1 before the rising
  // edge), check outputs against the model, then advance the model by the
  // inputs the coming rising edge will sample.
  initial begin
    m_st = 0; m_cnt = 0; m_err = 0; m_rd = 0; m_rd_ok = 1;
    forever begin
      @(negedge clk);
      #4;
      if (!reset_n) begin
        check("rst gray_ready", int'(gray_ready), 0);
        check("rst done", int'(done), 0);
        check("rst wr_cnt", int'(wr_cnt), 0);
        check("rst err_border", int'(err_border), 0);
        check("rst rd_data", int'(rd_data), 0);
        check("rst gray_data", int'(gray_data), 0);
        m_st = 0; m_cnt = 0; m_err = 0; m_rd = 0; m_rd_ok = 1;
      end else begin
        check("gray_ready", int'(gray_ready), int'(m_st == 1));
        check("done", int'(done), int'(m_st == 2));
        check("wr_cnt", int'(wr_cnt), m_cnt);
        check("err_border", int'(err_border), int'(m_err));
        check("state", int'(dbg_state == exp_state(m_st)), 1);
        if (m_rd_ok) check("rd_data", int'(rd_data), m_rd);
        if (m_st == 1 && gray_req) begin
          if (m_img_ok[gray_addr]) check("gray_data", int'(gray_data), int'(m_img[gray_addr]));
        end else begin
          check("gray_data idle", int'(gray_data), 0);
        end
        // readback sees the RAM before this edge's write
        m_rd_ok = border(int'(rd_addr)) || m_res_ok[rd_addr];
        m_rd    = border(int'(rd_addr)) ? 0 : int'(m_res[rd_addr]);
        case (m_st)
          0: begin
            if (ld_we) begin
              m_img[ld_addr] = ld_data;
              m_img_ok[ld_addr] = 1;
            end
            if (ld_done) m_st = 1;
          end
          1: begin
            if (lbp_valid) begin
              m_res[lbp_addr] = lbp_data;
              m_res_ok[lbp_addr] = 1;
              if (m_cnt < CNT_MAX) m_cnt++;
              if (border(int'(lbp_addr))) m_err = 1;
            end
            if (finish) m_st = 2;
          end
          default: begin
            if (host_clr) begin
              m_st = 0; m_cnt = 0; m_err = 0;
            end
          end
        endcase
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clr_in();
    ld_we = 0; ld_done = 0; host_clr = 0;
    gray_req = 0; lbp_valid = 0; finish = 0;
  endtask

  // ---------------- stimulus ----------------
  int c0;

  initial begin
    #1 reset_n = 0;
    repeat (3) tick();
    #4;
    check("lit reset gray_ready", int'(gray_ready), 0);
    check("lit reset wr_cnt", int'(wr_cnt), 0);
    tick();
    reset_n = 1;

    // Ramp into rows 0..7 while engine-side and clear inputs toggle randomly.
    for (int a = 0; a < 1024; a++) begin
      tick(); clr_in();
      ld_we = 1; ld_addr = AW'(a); ld_data = 8'(a);
      gray_req  = 1'($urandom);  gray_addr = AW'($urandom);
      lbp_valid = 1'($urandom);  lbp_addr  = AW'($urandom);
      lbp_data  = 8'($urandom);  finish    = 1'($urandom);
      host_clr  = 1'($urandom);  rd_addr   = AW'($urandom);
    end
    tick(); clr_in(); ld_done = 1;
    tick(); clr_in(); gray_req = 1; gray_addr = AW'(129);
    #4;
    check("lit ramp gray_ready", int'(gray_ready), 1);
    check("lit ramp gray 129", int'(gray_data), 'h81);
    tick(); clr_in(); gray_addr = AW'(129);
    #4;
    check("lit gray_req=0", int'(gray_data), 0);

    // Row-0 result sets the sticky border flag.
    check("lit err before", int'(err_border), 0);
    tick(); clr_in(); lbp_valid = 1; lbp_addr = AW'(5); lbp_data = 8'h3C;
    tick(); clr_in();
    #4;
    check("lit err row0", int'(err_border), 1);

    // Random serving traffic; loader inputs must be ignored.
    for (int i = 0; i < 400; i++) begin
      tick(); clr_in();
      gray_req  = 1'($urandom);  gray_addr = AW'($urandom_range(0, 1023));
      lbp_valid = 1'($urandom);  lbp_addr  = AW'($urandom_range(0, 511));
      lbp_data  = 8'($urandom);  rd_addr   = AW'($urandom_range(0, 511));
      ld_we     = 1'($urandom);  ld_addr   = AW'($urandom_range(0, 1023));
      ld_data   = 8'($urandom);  ld_done   = 1'($urandom);
      host_clr  = 1'($urandom);
    end
    tick(); clr_in(); ld_we = 1; ld_addr = AW'(200); ld_data = 8'h11;
    tick(); clr_in(); gray_req = 1; gray_addr = AW'(200);
    #4;
    check("lit ld_we in SERVE", int'(gray_data), 'hC8);

    // Capture and finish in one cycle, then a write in DONE is dropped.
    tick(); clr_in(); lbp_valid = 1; lbp_addr = AW'(300); lbp_data = 8'hA5; finish = 1;
    #2 c0 = m_cnt;
    tick(); clr_in(); lbp_valid = 1; lbp_addr = AW'(301); lbp_data = 8'h00; rd_addr = AW'(300);
    #4;
    check("lit done after finish", int'(done), 1);
    check("lit wr_cnt +1", int'(wr_cnt), c0 + 1);
    tick(); clr_in();
    #4;
    check("lit wr_cnt DONE hold", int'(wr_cnt), c0 + 1);
    check("lit rd 300", int'(rd_data), 'hA5);
    check("lit err sticky", int'(err_border), 1);
    tick(); clr_in(); host_clr = 1;
    tick(); clr_in();
    #4;
    check("lit clr done", int'(done), 0);
    check("lit clr wr_cnt", int'(wr_cnt), 0);
    check("lit clr err", int'(err_border), 0);

    // Reset mid-SERVE keeps the image.
    tick(); clr_in(); ld_done = 1;
    repeat (2) begin
      tick(); clr_in(); gray_req = 1; gray_addr = AW'($urandom_range(0, 1023));
    end
    tick(); clr_in(); reset_n = 0;
    #4;
    check("lit async reset gray_ready", int'(gray_ready), 0);
    tick(); reset_n = 1;
    tick(); clr_in(); ld_done = 1;
    tick(); clr_in(); gray_req = 1; gray_addr = AW'(129);
    #4;
    check("lit post-reset gray_ready", int'(gray_ready), 1);
    check("lit post-reset gray 129", int'(gray_data), 'h81);
    tick(); clr_in(); finish = 1;
    tick(); clr_in(); host_clr = 1;

    // Full constant image 0x40, then an engine pass over every interior pixel.
    for (int a = 0; a < N; a++) begin
      tick(); clr_in();
      ld_we = 1; ld_addr = AW'(a); ld_data = 8'h40; rd_addr = AW'($urandom);
    end
    tick(); clr_in(); ld_done = 1;
    for (int r = 1; r < H - 1; r++) begin
      for (int c = 1; c < W - 1; c++) begin
        tick(); clr_in();
        lbp_valid = 1; lbp_addr = AW'(r * W + c); lbp_data = lbp_ref(r * W + c);
        gray_req  = 1'($urandom); gray_addr = AW'($urandom);
        rd_addr   = AW'($urandom);
      end
    end
    tick(); clr_in(); finish = 1;
    tick(); clr_in(); rd_addr = AW'(129);
    #4;
    check("lit run done", int'(done), 1);
    check("lit run wr_cnt", int'(wr_cnt), 15876);
    check("lit run err", int'(err_border), 0);
    tick(); clr_in(); rd_addr = AW'(0);
    #4;
    check("lit rd 129", int'(rd_data), 'hFF);
    tick(); clr_in();
    #4;
    check("lit rd 0 border", int'(rd_data), 0);

    // Saturate the result counter.
    tick(); clr_in(); host_clr = 1;
    tick(); clr_in(); ld_done = 1;
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      tick(); clr_in();
      lbp_valid = 1;
      lbp_addr  = AW'($urandom_range(1, H - 2) * W + $urandom_range(1, W - 2));
      lbp_data  = 8'($urandom);
      rd_addr   = AW'($urandom);
    end
    tick(); clr_in();
    #4;
    check("lit wr_cnt saturated", int'(wr_cnt), 32767);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
